fifo_16_burst_reader: RTL

- Read-side master for the 16-bit, 512-deep FIFO.
- On a start command it pulls exactly `len` words from the FIFO read port and forwards them on a valid/ready stream, flagging the final word.
- The FIFO read port has 1-cycle read latency. A 2-entry output buffer with credit accounting gives 1 word/cycle sustained throughput under back-pressure, with no overrun and no lost words.
- Sits between the FIFO and downstream consumers such as the multiplier datapath.

---
 rtl/fifo_16_burst_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fifo_16_burst_reader.sv
// Burst read master: pulls len words from a 1-cycle-latency FIFO read port and
// forwards them on a valid/ready stream through a 2-entry credit-managed buffer.
module fifo_16_burst_reader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              fifo_rd_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  sent_q, sent_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] buf_q [2];
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;

    logic       pop;
    logic       push;
    logic       rd_acc;
    logic [2:0] credit;

    assign pop  = m_valid && m_ready;
    assign push = pend_q;

    // Words held or in flight after this cycle's pop; a new read needs a free slot.
    assign credit = {1'b0, buf_cnt_q} + 3'(pend_q) - 3'(pop);

    assign fifo_rd_en = (state_q == StRun) && !fifo_empty && (issued_q < len_q)
                        && (credit < 3'd2);
    assign rd_acc     = fifo_rd_en && !fifo_empty;

    assign m_valid = (buf_cnt_q != 2'd0);
    assign m_data  = buf_q[rd_ptr_q];
    assign m_last  = m_valid && (sent_q == len_q - LEN_W'(1));

    assign busy = (state_q == StRun) || (state_q == StDrain);
    assign done = (state_q == StDone);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        issued_d  = issued_q + LEN_W'(rd_acc);
        sent_d    = sent_q + LEN_W'(pop);
        pend_d    = rd_acc;
        buf_cnt_d = buf_cnt_q + 2'(push) - 2'(pop);
        wr_ptr_d  = wr_ptr_q ^ push;
        rd_ptr_d  = rd_ptr_q ^ pop;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len != '0) begin
                        len_d    = len;
                        issued_d = '0;
                        sent_d   = '0;
                        state_d  = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (issued_d == len_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Leave on the last handshake so done lands in the following cycle.
                if (!pend_q && (buf_cnt_d == 2'd0) && (sent_d == len_q)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            len_q     <= '0;
            issued_q  <= '0;
            sent_q    <= '0;
            pend_q    <= 1'b0;
            buf_cnt_q <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            sent_q    <= sent_d;
            pend_q    <= pend_d;
            buf_cnt_q <= buf_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else if (push) begin
            buf_q[wr_ptr_q] <= fifo_rd_data;
        end
    end

    buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (buf_cnt_q == 2'd2)));

endmodule
